// File: rtl/peripheral_bus_bridge_if.sv
// Request/response channel between a bus master and the peripheral bus bridge.
// One request channel (valid/ready) and one response channel (valid/ready).
interface peripheral_bus_bridge_if #(
   parameter int ADDRWIDTH = 9,
   parameter int DATAWIDTH = 32
);
   logic                 bus_valid;
   logic                 bus_ready;
   logic                 bus_we;
   logic [ADDRWIDTH-1:0] bus_addr;
   logic [DATAWIDTH-1:0] bus_wdata;
   logic                 bus_resp_valid;
   logic                 bus_resp_ready;
   logic [DATAWIDTH-1:0] bus_rdata;
   logic                 bus_err;

   modport master (
      output bus_valid, bus_we, bus_addr, bus_wdata, bus_resp_ready,
      input  bus_ready, bus_resp_valid, bus_rdata, bus_err
   );

   modport slave (
      input  bus_valid, bus_we, bus_addr, bus_wdata, bus_resp_ready,
      output bus_ready, bus_resp_valid, bus_rdata, bus_err
   );
endinterface

// File: rtl/peripheral_bus_bridge.sv
// Peripheral bus bridge: accepts one bus transaction at a time, decodes the
// word address into a core register access (MSB 0) or a core memory access
// (MSB 1), and returns the result on a valid/ready response channel.
// Register and memory write strobes are registered and last exactly one cycle.
module peripheral_bus_bridge #(
   parameter int DATAWIDTH = 32,
   parameter int REGS      = 3,
   parameter int MEMDEPTH  = 256,
   parameter int ADDRWIDTH = 9
) (
   input  logic                               clk,
   input  logic                               reset,
   peripheral_bus_bridge_if.slave             bus,
   output logic [REGS-1:0]                    reg_write_en,
   output logic [DATAWIDTH-1:0]               reg_data_in,
   input  logic [REGS*DATAWIDTH-1:0]          reg_data_out,
   output logic                               mem_write_en,
   output logic [$clog2(MEMDEPTH)-1:0]        mem_address,
   output logic [DATAWIDTH-1:0]               mem_data_in,
   input  logic [DATAWIDTH-1:0]               mem_data_out
);

   localparam int MEMADDRW = $clog2(MEMDEPTH);
   localparam int IDXW     = ADDRWIDTH - 1;
   localparam logic [IDXW-1:0] REGS_IDX = IDXW'(REGS);

   // The region bit must sit above the memory word address.
   if (ADDRWIDTH <= MEMADDRW) begin : g_bad_addrwidth
      $error("peripheral_bus_bridge: ADDRWIDTH must exceed clog2(MEMDEPTH)");
   end

   typedef enum logic [1:0] {
      IDLE,
      EXEC,
      MEM_WAIT,
      RESP
   } state_t;

   state_t                state_q;

   // Latched request attributes, valid from EXEC onwards.
   logic                  we_q;
   logic                  mem_sel_q;
   logic                  reg_ok_q;
   logic [IDXW-1:0]       idx_q;

   // Registered outputs.
   logic                  resp_valid_q;
   logic [DATAWIDTH-1:0]  rdata_q;
   logic                  err_q;
   logic [REGS-1:0]       reg_we_q;
   logic [DATAWIDTH-1:0]  reg_din_q;
   logic                  mem_we_q;
   logic [MEMADDRW-1:0]   mem_addr_q;
   logic [DATAWIDTH-1:0]  mem_din_q;

   // Next values of the write strobes: only ever non-zero on the accepting edge,
   // so each strobe is high for the single EXEC cycle that follows.
   logic [REGS-1:0]       reg_we_d;
   logic                  mem_we_d;

   logic                  bus_ready_w;
   logic                  accept;
   logic                  req_mem;
   logic [IDXW-1:0]       req_idx;
   logic [MEMADDRW-1:0]   req_maddr;
   logic                  req_reg_ok;
   logic [DATAWIDTH-1:0]  reg_rd_sel;

   // Ready only while idle and never during reset.
   assign bus_ready_w = (state_q == IDLE) && !reset;
   assign accept      = bus.bus_valid && bus_ready_w;

   assign req_mem     = bus.bus_addr[ADDRWIDTH-1];
   assign req_idx     = bus.bus_addr[IDXW-1:0];
   assign req_maddr   = bus.bus_addr[MEMADDRW-1:0];
   assign req_reg_ok  = !req_mem && (req_idx < REGS_IDX);

   // Decode the write strobe for the request being accepted this cycle.
   always_comb begin
      reg_we_d = '0;
      mem_we_d = 1'b0;
      if (accept && bus.bus_we) begin
         if (req_mem) begin
            mem_we_d = 1'b1;
         end else if (req_reg_ok) begin
            reg_we_d = REGS'(1) << req_idx;
         end
      end
   end

   // Select the read-back word of the latched register index.
   always_comb begin
      reg_rd_sel = '0;
      for (int i = 0; i < REGS; i++) begin
         if (idx_q == IDXW'(i)) begin
            reg_rd_sel = reg_data_out[i*DATAWIDTH +: DATAWIDTH];
         end
      end
   end

   // Transaction sequencer; all bridge outputs are registers of this block.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         we_q         <= 1'b0;
         mem_sel_q    <= 1'b0;
         reg_ok_q     <= 1'b0;
         idx_q        <= '0;
         resp_valid_q <= 1'b0;
         rdata_q      <= '0;
         err_q        <= 1'b0;
         reg_we_q     <= '0;
         reg_din_q    <= '0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_din_q    <= '0;
      end else begin
         reg_we_q <= reg_we_d;
         mem_we_q <= mem_we_d;
         case (state_q)
            IDLE: begin
               if (accept) begin
                  we_q      <= bus.bus_we;
                  mem_sel_q <= req_mem;
                  reg_ok_q  <= req_reg_ok;
                  idx_q     <= req_idx;
                  if (req_mem) begin
                     // Address bits between the region bit and the memory
                     // word address are ignored rather than flagged.
                     mem_addr_q <= req_maddr;
                     if (bus.bus_we) begin
                        mem_din_q <= bus.bus_wdata;
                     end
                  end else if (bus.bus_we && req_reg_ok) begin
                     reg_din_q <= bus.bus_wdata;
                  end
                  state_q <= EXEC;
               end
            end
            EXEC: begin
               if (mem_sel_q) begin
                  if (we_q) begin
                     rdata_q      <= '0;
                     err_q        <= 1'b0;
                     resp_valid_q <= 1'b1;
                     state_q      <= RESP;
                  end else begin
                     // The memory returns data one cycle after the address.
                     state_q <= MEM_WAIT;
                  end
               end else begin
                  if (!reg_ok_q) begin
                     rdata_q <= '0;
                     err_q   <= 1'b1;
                  end else if (!we_q) begin
                     rdata_q <= reg_rd_sel;
                     err_q   <= 1'b0;
                  end else begin
                     rdata_q <= '0;
                     err_q   <= 1'b0;
                  end
                  resp_valid_q <= 1'b1;
                  state_q      <= RESP;
               end
            end
            MEM_WAIT: begin
               rdata_q      <= mem_data_out;
               err_q        <= 1'b0;
               resp_valid_q <= 1'b1;
               state_q      <= RESP;
            end
            RESP: begin
               if (bus.bus_resp_ready) begin
                  resp_valid_q <= 1'b0;
                  rdata_q      <= '0;
                  err_q        <= 1'b0;
                  state_q      <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus.bus_ready      = bus_ready_w;
   assign bus.bus_resp_valid = resp_valid_q;
   assign bus.bus_rdata      = rdata_q;
   assign bus.bus_err        = err_q;

   assign reg_write_en = reg_we_q;
   assign reg_data_in  = reg_din_q;
   assign mem_write_en = mem_we_q;
   assign mem_address  = mem_addr_q;
   assign mem_data_in  = mem_din_q;

endmodule

// File: tb/tb_peripheral_bus_bridge.sv
// Testbench for peripheral_bus_bridge: a core model (registers + synchronous
// memory) sits behind the bridge, and a transaction-level reference model
// predicts every response, strobe, latency and accept spacing.
`timescale 1ns/1ps
module tb_peripheral_bus_bridge;

   localparam int DW    = 32;
   localparam int REGS  = 3;
   localparam int DEPTH = 256;
   localparam int AW    = 9;
   localparam int MAW   = 8;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   peripheral_bus_bridge_if #(.ADDRWIDTH(AW), .DATAWIDTH(DW)) bus ();

   logic [REGS-1:0]      reg_write_en;
   logic [DW-1:0]        reg_data_in;
   logic [REGS*DW-1:0]   reg_data_out;
   logic                 mem_write_en;
   logic [MAW-1:0]       mem_address;
   logic [DW-1:0]        mem_data_in;
   logic [DW-1:0]        mem_data_out;

   peripheral_bus_bridge #(
      .DATAWIDTH(DW), .REGS(REGS), .MEMDEPTH(DEPTH), .ADDRWIDTH(AW)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .bus          (bus),
      .reg_write_en (reg_write_en),
      .reg_data_in  (reg_data_in),
      .reg_data_out (reg_data_out),
      .mem_write_en (mem_write_en),
      .mem_address  (mem_address),
      .mem_data_in  (mem_data_in),
      .mem_data_out (mem_data_out)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [DW-1:0] seed_word(input int i);
      return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A5A5A;
   endfunction

   // Core environment: registers written by strobes, synchronous memory.
   logic [DW-1:0] core_regs [REGS];
   logic [DW-1:0] core_mem  [DEPTH];
   logic          env_init;

   always @(posedge clk) begin
      if (env_init) begin
         for (int i = 0; i < REGS; i++) core_regs[i] <= seed_word(i + 1000);
         for (int i = 0; i < DEPTH; i++) core_mem[i] <= seed_word(i);
      end else begin
         for (int i = 0; i < REGS; i++) if (reg_write_en[i]) core_regs[i] <= reg_data_in;
         if (mem_write_en) core_mem[mem_address] <= mem_data_in;
      end
      mem_data_out <= core_mem[mem_address];
   end

   for (genvar g = 0; g < REGS; g++) begin : g_rd
      assign reg_data_out[g*DW +: DW] = core_regs[g];
   end

   // Reference model: architectural contents as seen by the bus master.
   logic [DW-1:0] ref_regs [REGS];
   logic [DW-1:0] ref_mem  [DEPTH];

   // Runs one transaction starting at a negedge; returns at the negedge after
   // the response handshake, which is where the next request may be driven.
   task automatic run_txn(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                          input int stall, input bit hold_valid, output int acc_cyc);
      logic          is_mem;
      int            idx_i;
      logic          err_e;
      int            lat_e;
      logic [DW-1:0] rd_e;
      logic [REGS-1:0] rwe_e;
      logic          mwe_e;
      logic [REGS-1:0] rwe_now;
      logic          mwe_now;
      int            waitn;
      bit            got;

      is_mem = addr[AW-1];
      idx_i  = int'(addr[AW-2:0]);
      err_e  = !is_mem && (idx_i >= REGS);
      lat_e  = (is_mem && !we) ? 3 : 2;
      if (we || err_e)  rd_e = '0;
      else if (is_mem)  rd_e = ref_mem[int'(addr[MAW-1:0])];
      else              rd_e = ref_regs[idx_i];
      rwe_e = (we && !is_mem && !err_e) ? (REGS'(1) << idx_i) : '0;
      mwe_e = we && is_mem;

      waitn = 0;
      while (bus.bus_ready !== 1'b1 && waitn < 20) begin
         @(negedge clk);
         waitn++;
      end
      n_checks++;
      if (bus.bus_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL accept_wait: bus_ready=%b required 1", bus.bus_ready);
      end

      bus.bus_valid      = 1'b1;
      bus.bus_we         = we;
      bus.bus_addr       = addr;
      bus.bus_wdata      = wd;
      bus.bus_resp_ready = (stall == 0);
      acc_cyc            = cyc;
      @(negedge clk);
      bus.bus_valid = hold_valid;
      bus.bus_we    = 1'($urandom);
      bus.bus_addr  = AW'($urandom);
      bus.bus_wdata = $urandom;

      got = 0;
      for (int c = 1; c <= 12 && !got; c++) begin
         rwe_now = (c == 1) ? rwe_e : '0;
         mwe_now = (c == 1) ? mwe_e : 1'b0;
         n_checks++;
         if (reg_write_en !== rwe_now) begin
            n_fail++;
            $display("FAIL reg_strobe addr=%h cyc+%0d: got %b required %b", addr, c, reg_write_en, rwe_now);
         end
         n_checks++;
         if (mem_write_en !== mwe_now) begin
            n_fail++;
            $display("FAIL mem_strobe addr=%h cyc+%0d: got %b required %b", addr, c, mem_write_en, mwe_now);
         end
         if (c == 1 && rwe_e != '0) begin
            n_checks++;
            if (reg_data_in !== wd) begin
               n_fail++;
               $display("FAIL reg_data_in: got %h required %h", reg_data_in, wd);
            end
         end
         if (c == 1 && is_mem) begin
            n_checks++;
            if (mem_address !== addr[MAW-1:0]) begin
               n_fail++;
               $display("FAIL mem_address: got %h required %h", mem_address, addr[MAW-1:0]);
            end
            if (we) begin
               n_checks++;
               if (mem_data_in !== wd) begin
                  n_fail++;
                  $display("FAIL mem_data_in: got %h required %h", mem_data_in, wd);
               end
            end
         end
         n_checks++;
         if (bus.bus_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_ready addr=%h cyc+%0d: got %b required 0", addr, c, bus.bus_ready);
         end
         if (bus.bus_resp_valid === 1'b1) begin
            got = 1;
            n_checks++;
            if (c != lat_e) begin
               n_fail++;
               $display("FAIL latency addr=%h we=%b: got %0d required %0d", addr, we, c, lat_e);
            end
            n_checks++;
            if (bus.bus_rdata !== rd_e) begin
               n_fail++;
               $display("FAIL rdata addr=%h: got %h required %h", addr, bus.bus_rdata, rd_e);
            end
            n_checks++;
            if (bus.bus_err !== err_e) begin
               n_fail++;
               $display("FAIL err addr=%h: got %b required %b", addr, bus.bus_err, err_e);
            end
            for (int s = 0; s < stall; s++) begin
               @(negedge clk);
               n_checks++;
               if (bus.bus_resp_valid !== 1'b1 || bus.bus_rdata !== rd_e || bus.bus_err !== err_e ||
                   bus.bus_ready !== 1'b0 || reg_write_en !== '0 || mem_write_en !== 1'b0) begin
                  n_fail++;
                  $display("FAIL stall_hold s=%0d: vld=%b rdata=%h err=%b rdy=%b rwe=%b mwe=%b required 1 %h %b 0 0 0",
                           s, bus.bus_resp_valid, bus.bus_rdata, bus.bus_err, bus.bus_ready,
                           reg_write_en, mem_write_en, rd_e, err_e);
               end
            end
            bus.bus_resp_ready = 1'b1;
            @(negedge clk);
            n_checks++;
            if (bus.bus_resp_valid !== 1'b0 || bus.bus_rdata !== '0 || bus.bus_err !== 1'b0 ||
                bus.bus_ready !== 1'b1) begin
               n_fail++;
               $display("FAIL after_handshake: vld=%b rdata=%h err=%b rdy=%b required 0 0 0 1",
                        bus.bus_resp_valid, bus.bus_rdata, bus.bus_err, bus.bus_ready);
            end
         end else begin
            @(negedge clk);
         end
      end
      if (!got) begin
         n_checks++;
         n_fail++;
         $display("FAIL resp_timeout addr=%h: resp_valid=%b required 1", addr, bus.bus_resp_valid);
      end

      if (we && !err_e) begin
         if (is_mem) ref_mem[int'(addr[MAW-1:0])] = wd;
         else        ref_regs[idx_i] = wd;
      end
   endtask

   task automatic test_reset();
      reset    = 1'b1;
      env_init = 1'b1;
      repeat (2) @(negedge clk);
      n_checks++;
      if (bus.bus_ready !== 1'b0 || bus.bus_resp_valid !== 1'b0 || bus.bus_rdata !== '0 ||
          bus.bus_err !== 1'b0 || reg_write_en !== '0 || reg_data_in !== '0 ||
          mem_write_en !== 1'b0 || mem_address !== '0 || mem_data_in !== '0) begin
         n_fail++;
         $display("FAIL reset_values: rdy=%b vld=%b rdata=%h err=%b rwe=%b rdin=%h mwe=%b maddr=%h mdin=%h required all 0",
                  bus.bus_ready, bus.bus_resp_valid, bus.bus_rdata, bus.bus_err, reg_write_en,
                  reg_data_in, mem_write_en, mem_address, mem_data_in);
      end
      reset    = 1'b0;
      env_init = 1'b0;
      @(negedge clk);
      n_checks++;
      if (bus.bus_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL ready_after_reset: got %b required 1", bus.bus_ready);
      end
   endtask

   task automatic test_reg_write_read();
      int a;
      run_txn(1'b1, 9'h001, 32'h0000_0005, 0, 1'b0, a);
      run_txn(1'b0, 9'h001, 32'h0, 0, 1'b0, a);
      n_checks++;
      if (ref_regs[1] !== 32'h0000_0005) begin
         n_fail++;
         $display("FAIL reg1_model: got %h required 00000005", ref_regs[1]);
      end
   endtask

   task automatic test_reg_error();
      int a;
      run_txn(1'b0, 9'h003, 32'h0, 0, 1'b0, a);
      run_txn(1'b1, 9'h0FF, 32'h1234_5678, 0, 1'b0, a);
   endtask

   task automatic test_mem();
      int a;
      run_txn(1'b1, 9'h1A5, 32'hDEAD_BEEF, 0, 1'b0, a);
      run_txn(1'b0, 9'h1A5, 32'h0, 0, 1'b0, a);
   endtask

   task automatic test_backpressure();
      int a0, a1;
      run_txn(1'b0, 9'h001, 32'h0, 5, 1'b0, a0);
      run_txn(1'b0, 9'h000, 32'h0, 0, 1'b0, a1);
      n_checks++;
      if (a1 - a0 != 2 + 5 + 1) begin
         n_fail++;
         $display("FAIL backpressure_accept: spacing %0d required %0d", a1 - a0, 8);
      end
   endtask

   task automatic test_back_to_back();
      int a0, a1, a2, a3;
      run_txn(1'b1, 9'h000, $urandom, 0, 1'b1, a0);
      run_txn(1'b1, 9'h001, $urandom, 0, 1'b1, a1);
      run_txn(1'b1, 9'h002, $urandom, 0, 1'b1, a2);
      run_txn(1'b0, 9'h150, 32'h0, 0, 1'b1, a3);
      bus.bus_valid = 1'b0;
      n_checks++;
      if (a1 - a0 != 3 || a2 - a1 != 3) begin
         n_fail++;
         $display("FAIL b2b_spacing: got %0d %0d required 3 3", a1 - a0, a2 - a1);
      end
      run_txn(1'b0, 9'h002, 32'h0, 0, 1'b0, a0);
      n_checks++;
      if (a0 - a3 != 4) begin
         n_fail++;
         $display("FAIL memread_period: got %0d required 4", a0 - a3);
      end
   endtask

   task automatic test_reset_mid_resp();
      int  waitn;
      bus.bus_valid      = 1'b1;
      bus.bus_we         = 1'b0;
      bus.bus_addr       = 9'h1A5;
      bus.bus_wdata      = '0;
      bus.bus_resp_ready = 1'b0;
      @(negedge clk);
      bus.bus_valid = 1'b0;
      waitn = 0;
      while (bus.bus_resp_valid !== 1'b1 && waitn < 10) begin
         @(negedge clk);
         waitn++;
      end
      n_checks++;
      if (bus.bus_resp_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_setup: resp_valid=%b required 1", bus.bus_resp_valid);
      end
      reset = 1'b1;
      #1;
      n_checks++;
      if (bus.bus_resp_valid !== 1'b0 || bus.bus_ready !== 1'b0 || bus.bus_rdata !== '0 ||
          bus.bus_err !== 1'b0 || mem_address !== '0) begin
         n_fail++;
         $display("FAIL async_reset: vld=%b rdy=%b rdata=%h err=%b maddr=%h required 0 0 0 0 0",
                  bus.bus_resp_valid, bus.bus_ready, bus.bus_rdata, bus.bus_err, mem_address);
      end
      @(negedge clk);
      reset              = 1'b0;
      bus.bus_resp_ready = 1'b1;
      @(negedge clk);
      n_checks++;
      if (bus.bus_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL ready_after_midreset: got %b required 1", bus.bus_ready);
      end
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         n_checks++;
         if (bus.bus_resp_valid !== 1'b0 || reg_write_en !== '0 || mem_write_en !== 1'b0) begin
            n_fail++;
            $display("FAIL dropped_txn k=%0d: vld=%b rwe=%b mwe=%b required 0 0 0",
                     k, bus.bus_resp_valid, reg_write_en, mem_write_en);
         end
      end
   endtask

   task automatic test_random();
      int            a;
      logic [AW-1:0] addr;
      for (int k = 0; k < 60; k++) begin
         case ($urandom_range(0, 3))
            0:       addr = {1'b0, 8'($urandom_range(0, REGS - 1))};
            1:       addr = {1'b0, 8'($urandom)};
            default: addr = {1'b1, 8'($urandom_range(0, 15))};
         endcase
         run_txn(1'($urandom), addr, $urandom, $urandom_range(0, 2), 1'($urandom), a);
         bus.bus_valid = 1'b0;
      end
   endtask

   initial begin
      bus.bus_valid      = 1'b0;
      bus.bus_we         = 1'b0;
      bus.bus_addr       = '0;
      bus.bus_wdata      = '0;
      bus.bus_resp_ready = 1'b1;
      for (int i = 0; i < REGS; i++) ref_regs[i] = seed_word(i + 1000);
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = seed_word(i);

      test_reset();
      test_reg_write_read();
      test_reg_error();
      test_mem();
      test_backpressure();
      test_back_to_back();
      test_reset_mid_resp();
      test_random();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/peripheral_bus_bridge.md
Name: peripheral_bus_bridge

Overview:
Bus slave that sits directly upstream of the peripheral core. It accepts single bus transactions over a valid/ready request channel and decodes each word address into either a core register access or a core memory access. For register accesses it drives one-hot register write-enables and muxes the register read-back array. For memory accesses it drives the synchronous single-port memory. It returns each result on a valid/ready response channel, with one transaction outstanding at a time.

Parameters:
DATAWIDTH, 32, width of bus, register and memory data
REGS, 3, number of core registers; register indices 0..REGS-1 are valid
MEMDEPTH, 256, memory words; MEMADDRW = $clog2(MEMDEPTH)
ADDRWIDTH, 9, bus word-address width; the MSB selects the region; must be > MEMADDRW

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
bus_valid  in  1  request valid
bus_ready  out  1  bridge can accept a request
bus_we  in  1  1 = write, 0 = read
bus_addr  in  ADDRWIDTH  word address; MSB 0 = register region, 1 = memory region
bus_wdata  in  DATAWIDTH  write data
bus_resp_valid  out  1  response valid
bus_resp_ready  in  1  master accepts response
bus_rdata  out  DATAWIDTH  read data (0 for writes and errors)
bus_err  out  1  response is an error
reg_write_en  out  REGS  one-hot register write strobe to core
reg_data_in  out  DATAWIDTH  register write data to core
reg_data_out  in  REGS*DATAWIDTH  flattened core register read-back; register i is at [i*DATAWIDTH +: DATAWIDTH]
mem_write_en  out  1  memory write strobe
mem_address  out  MEMADDRW  memory word address
mem_data_in  out  DATAWIDTH  memory write data
mem_data_out  in  DATAWIDTH  memory read data, valid 1 cycle after the address is presented

Behaviour:
- Clocking and reset: one clock (clk); reset is asynchronous and active-high.
- States: IDLE, EXEC, MEM_WAIT, RESP.
- Reset (async, any state): state=IDLE; bus_resp_valid=0, bus_rdata=0, bus_err=0, reg_write_en=0, reg_data_in=0, mem_write_en=0, mem_address=0, mem_data_in=0.
  - Any in-flight transaction is dropped with no response and no strobe.
  - No request is accepted while reset is asserted.
- bus_ready = (state==IDLE) and not reset.
- Handshake:
  - A request is accepted in cycle N when bus_valid && bus_ready.
  - The bridge latches we, addr and wdata at that edge.
  - bus_wdata and bus_addr are ignored outside the accepting cycle.
- EXEC (cycle N+1):
  - Register write, index < REGS: reg_write_en[index]=1 for exactly this cycle; reg_data_in=latched wdata. Next state RESP.
  - Register read, index < REGS: capture reg_data_out[index] into bus_rdata at the end of EXEC. Next state RESP.
  - Register index >= REGS (index = addr[ADDRWIDTH-2:0]): no strobe; bus_rdata=0, bus_err=1. Next state RESP.
  - Memory access (addr MSB=1): mem_address = addr[MEMADDRW-1:0]; upper unused address bits are ignored (no error).
  - Memory write: mem_write_en=1 for exactly this cycle; mem_data_in=wdata. Next state RESP.
  - Memory read: mem_write_en=0. Next state MEM_WAIT.
- MEM_WAIT (N+2): capture mem_data_out into bus_rdata; mem_address is held. Next state RESP.
- RESP: bus_resp_valid=1.
  - bus_rdata and bus_err are held stable until bus_resp_ready=1.
  - On handshake: bus_resp_valid=0, bus_err=0, rdata cleared to 0, state IDLE.
- Latency from accept to first response-valid cycle:
  - Register read/write and error: 2 cycles (resp_valid in N+2).
  - Memory read: 3 cycles (N+3). Memory write: 2 cycles.
- Throughput: with resp_ready held high, a new request can be accepted the cycle after the response handshake. Minimum period is 3 cycles for register/write accesses and 4 cycles for memory reads.
- Strobes: reg_write_en and mem_write_en are registered outputs.
  - Never more than one bit high at a time.
  - Never high outside EXEC.
  - Never repeated while a response is stalled.
- Register reads: return the core value sampled in EXEC. A concurrently counting register returns its value at that edge.
- Writes return bus_rdata=0 and bus_err=0.

Test Plan:
- Reset check: reset pulsed mid-RESP of a memory read -> bus_resp_valid=0 immediately; state IDLE; bus_ready=1 the cycle after deassertion; no response for the dropped request.
- Register write/read: write addr=0x001 data=0x00000005 -> reg_write_en=3'b010 for exactly one cycle in N+1, reg_data_in=0x5, resp in N+2 with err=0. Then read addr=0x001 with the core returning 0x5 -> bus_rdata=0x00000005 in N+2.
- Register error: read addr=0x003 (REGS=3) -> reg_write_en stays 0, bus_err=1, bus_rdata=0 in N+2. Write addr=0x0FF -> bus_err=1, no strobe.
- Memory path: write addr=0x1A5 data=0xDEADBEEF -> mem_write_en=1 and mem_address=0xA5 in N+1. Then read addr=0x1A5 -> bus_rdata=0xDEADBEEF with resp_valid first high in N+3.
- Backpressure: hold bus_resp_ready=0 for 5 cycles after a register read -> bus_resp_valid, bus_rdata and bus_err are stable; bus_ready=0 throughout; no extra strobes; a new request is accepted the cycle after resp_ready=1.
- Back-to-back: writes to registers 0, 1 and 2 with bus_valid held high and resp_ready=1 -> accepts spaced 3 cycles apart; strobes 001, 010, 100 each one cycle.
